sinit_gen: RTL and testbench

- Parametrised state-array initialiser; next generation of the ARC4 `init` block.
- Fills a `2**ADDR_W` × `DATA_W` single-port memory, one write per cycle, using a run-time selected pattern.
- Patterns: identity with offset, reverse, or constant fill.
- Sits between the top-level controller and the S-memory write port, using the same `en`/`rdy` handshake as the other ARC4 stages.

---
 rtl/sinit_pkg.sv | 24 ++
 rtl/sinit_valgen.sv | 44 ++++
 rtl/sinit_gen.sv | 173 +++++++++++++++++
 tb/tb_sinit_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sinit_pkg.sv
// Shared types for the S-array initialiser: pattern select and controller state.
// No logic here; SINIT_VERIFY_EN adds the VERIFY state encoding.
// Backpressure: not applicable (type definitions only).
package sinit_pkg;

   // Pattern select sampled at start; MODE_RSVD aliases the identity pattern
   typedef enum logic [1:0] {
      MODE_IDENT = 2'd0,
      MODE_REV   = 2'd1,
      MODE_FILL  = 2'd2,
      MODE_RSVD  = 2'd3
   } sinit_mode_t;

   // Controller state
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WRITE  = 2'd1
`ifdef SINIT_VERIFY_EN
      ,
      ST_VERIFY = 2'd2
`endif
   } sinit_state_t;

endpackage

// File: rtl/sinit_valgen.sv
// Pattern value generator: value(i) for identity+offset, reverse, or constant fill.
// Purely combinational, zero latency.
// Backpressure: none; output follows inputs.
module sinit_valgen
   import sinit_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic [ADDR_W-1:0] idx_i,
   input  sinit_mode_t       mode_i,
   input  logic [DATA_W-1:0] fill_i,
   output logic [DATA_W-1:0] val_o
);

   // DEPTH-1-i is simply the bitwise complement of i inside ADDR_W bits
   logic [ADDR_W-1:0] rev_idx;
   logic [DATA_W-1:0] idx_ext;
   logic [DATA_W-1:0] rev_ext;

   assign rev_idx = ~idx_i;

   // Bring the index into the data width: zero-extend when narrower, else truncate
   generate
      if (DATA_W > ADDR_W) begin : g_zext
         assign idx_ext = {{(DATA_W-ADDR_W){1'b0}}, idx_i};
         assign rev_ext = {{(DATA_W-ADDR_W){1'b0}}, rev_idx};
      end else begin : g_trunc
         assign idx_ext = idx_i[DATA_W-1:0];
         assign rev_ext = rev_idx[DATA_W-1:0];
      end
   endgenerate

   // Select the pattern; addition wraps modulo 2**DATA_W naturally
   always_comb begin
      val_o = idx_ext + fill_i;
      case (mode_i)
         MODE_REV:  val_o = rev_ext;
         MODE_FILL: val_o = fill_i;
         default:   val_o = idx_ext + fill_i;
      endcase
   end

endmodule

// File: rtl/sinit_gen.sv
// S-array initialiser: writes 2**ADDR_W words, one per cycle, with a selectable pattern.
// First write one cycle after the accepted start; rdy returns DEPTH+1 cycles later (2*DEPTH+2 with SINIT_VERIFY_EN read-back).
// Backpressure: en is only accepted while rdy=1; the write stream itself never stalls.
module sinit_gen
   import sinit_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] fill,
   output logic              rdy,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wrdata,
   output logic              wren
`ifdef SINIT_VERIFY_EN
   ,
   input  logic [DATA_W-1:0] rddata,
   output logic              err
`endif
);

   localparam int DEPTH = 2**ADDR_W;
   // One extra counter bit so the read-back phase can count to DEPTH without wrapping
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

   sinit_state_t      state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_inc;
   sinit_mode_t       mode_q;
   logic [DATA_W-1:0] fill_q;
   logic              rdy_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wrdata_q;
   logic              wren_q;

   logic [ADDR_W-1:0] wr_idx_d;
   sinit_mode_t       wr_mode_d;
   logic [DATA_W-1:0] wr_fill_d;
   logic [DATA_W-1:0] wr_val;

   assign cnt_inc = cnt_q + CNT_W'(1);

   // Write-path generator input: at start use the live mode/fill for index 0 so the
   // first word is ready on the first write cycle; afterwards use the latched copy
   always_comb begin
      wr_idx_d  = cnt_inc[ADDR_W-1:0];
      wr_mode_d = mode_q;
      wr_fill_d = fill_q;
      if (state_q == ST_IDLE) begin
         wr_idx_d  = '0;
         wr_mode_d = sinit_mode_t'(mode);
         wr_fill_d = fill;
      end
   end

   sinit_valgen #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_wr_val (
      .idx_i  (wr_idx_d),
      .mode_i (wr_mode_d),
      .fill_i (wr_fill_d),
      .val_o  (wr_val)
   );

`ifdef SINIT_VERIFY_EN
   localparam logic [CNT_W-1:0] END_IDX = CNT_W'(DEPTH);

   logic              err_q;
   logic [ADDR_W-1:0] exp_idx;
   logic [DATA_W-1:0] exp_val;
   logic              mismatch;

   // Read data arriving now belongs to the address issued one cycle earlier
   assign exp_idx  = cnt_q[ADDR_W-1:0] - ADDR_W'(1);
   assign mismatch = (cnt_q != '0) && (rddata != exp_val);

   sinit_valgen #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_exp_val (
      .idx_i  (exp_idx),
      .mode_i (mode_q),
      .fill_i (fill_q),
      .val_o  (exp_val)
   );

   assign err = err_q;
`endif

   // Controller FSM with all outputs held in registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         mode_q   <= MODE_IDENT;
         fill_q   <= '0;
         rdy_q    <= 1'b1;
         addr_q   <= '0;
         wrdata_q <= '0;
         wren_q   <= 1'b0;
`ifdef SINIT_VERIFY_EN
         err_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (en) begin
                  mode_q   <= sinit_mode_t'(mode);
                  fill_q   <= fill;
                  cnt_q    <= '0;
                  addr_q   <= '0;
                  wrdata_q <= wr_val;
                  wren_q   <= 1'b1;
                  rdy_q    <= 1'b0;
`ifdef SINIT_VERIFY_EN
                  err_q    <= 1'b0;
`endif
                  state_q  <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (cnt_q == LAST_IDX) begin
                  wren_q  <= 1'b0;
                  cnt_q   <= '0;
`ifdef SINIT_VERIFY_EN
                  addr_q  <= '0;
                  state_q <= ST_VERIFY;
`else
                  rdy_q   <= 1'b1;
                  state_q <= ST_IDLE;
`endif
               end else begin
                  cnt_q    <= cnt_inc;
                  addr_q   <= cnt_inc[ADDR_W-1:0];
                  wrdata_q <= wr_val;
               end
            end
`ifdef SINIT_VERIFY_EN
            ST_VERIFY: begin
               if (mismatch) begin
                  err_q <= 1'b1;
               end
               if (cnt_q == END_IDX) begin
                  rdy_q   <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_inc;
                  // Last read address stays put during the final compare cycle
                  if (cnt_q < LAST_IDX) begin
                     addr_q <= cnt_inc[ADDR_W-1:0];
                  end
               end
            end
`endif
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign rdy    = rdy_q;
   assign addr   = addr_q;
   assign wrdata = wrdata_q;
   assign wren   = wren_q;

endmodule

// File: tb/tb_sinit_gen.sv
// Bench for sinit_gen: three instances (ADDR_W = 8, 4, 1) with behavioural memory models.
// Every write/verify cycle is compared with a pattern model computed from the pattern rules.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_sinit_gen;

   logic       clk;
   logic       rst_n;
   logic       en_s   [3];
   logic [1:0] mode_s [3];
   logic [7:0] fill_s [3];
   logic       rdy_w  [3];
   logic [7:0] addr_w [3];
   logic [7:0] wd_w   [3];
   logic       wren_w [3];
   logic [7:0] mem    [3][256];
`ifdef SINIT_VERIFY_EN
   logic [7:0] rd_s      [3];
   logic       err_w     [3];
   logic       corrupt_s [3];
`endif

   int nchecks = 0;
   int nerrs   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int AWG = (g == 0) ? 8 : ((g == 1) ? 4 : 1);
      logic [AWG-1:0] a;
      sinit_gen #(
         .ADDR_W (AWG),
         .DATA_W (8)
      ) u_dut (
         .clk    (clk),
         .rst_n  (rst_n),
         .en     (en_s[g]),
         .mode   (mode_s[g]),
         .fill   (fill_s[g]),
         .rdy    (rdy_w[g]),
         .addr   (a),
         .wrdata (wd_w[g]),
         .wren   (wren_w[g])
`ifdef SINIT_VERIFY_EN
         ,
         .rddata (rd_s[g]),
         .err    (err_w[g])
`endif
      );
      assign addr_w[g] = 8'(a);
   end

   // Single-port memories with one-cycle read latency; optional bit flip at word 37
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (wren_w[d]) mem[d][addr_w[d]] <= wd_w[d];
`ifdef SINIT_VERIFY_EN
         rd_s[d] <= mem[d][addr_w[d]] ^ ((corrupt_s[d] && addr_w[d] == 8'd37) ? 8'h01 : 8'h00);
`endif
      end
   end

   function automatic int aw_of(int d);
      return (d == 0) ? 8 : ((d == 1) ? 4 : 1);
   endfunction

   // Pattern rules with plain integer arithmetic, reduced modulo 256
   function automatic int model(int i, int m, int f, int depth);
      if (m == 1) return (depth - 1 - i) % 256;
      if (m == 2) return f;
      return (i + f) % 256;
   endfunction

   task automatic check(string name, int act, int exp);
      nchecks++;
      if (act != exp) begin
         nerrs++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_rdy(int d);
      int n = 0;
      while (rdy_w[d] !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (rdy_w[d] !== 1'b1) check("rdy_timeout", 0, 1);
   endtask

   // One complete run on instance d, checked cycle by cycle; returns at the
   // falling edge of the first rdy=1 cycle after the run
   task automatic run(int d, int m, int f, bit scramble, bit hold);
      int depth = 1 << aw_of(d);
      wait_rdy(d);
      mode_s[d] = 2'(m);
      fill_s[d] = 8'(f);
      en_s[d]   = 1'b1;
      @(negedge clk);
      if (!hold) en_s[d] = 1'b0;
      for (int i = 0; i < depth; i++) begin
         check("wr_rdy",  int'(rdy_w[d]),  0);
         check("wr_wren", int'(wren_w[d]), 1);
         check("wr_addr", int'(addr_w[d]), i);
         check("wr_data", int'(wd_w[d]),   model(i, m, f, depth));
`ifdef SINIT_VERIFY_EN
         if (i == 0) check("err_clear", int'(err_w[d]), 0);
`endif
         if (scramble) begin
            mode_s[d] = 2'($urandom_range(0, 3));
            fill_s[d] = 8'($urandom_range(0, 255));
         end
         @(negedge clk);
      end
`ifdef SINIT_VERIFY_EN
      for (int j = 0; j <= depth; j++) begin
         check("vf_rdy",  int'(rdy_w[d]),  0);
         check("vf_wren", int'(wren_w[d]), 0);
         if (j < depth) check("vf_addr", int'(addr_w[d]), j);
         @(negedge clk);
      end
      check("vf_err", int'(err_w[d]), (corrupt_s[d] && depth > 37) ? 1 : 0);
`endif
      check("end_rdy",  int'(rdy_w[d]),  1);
      check("end_wren", int'(wren_w[d]), 0);
   endtask

   typedef struct {
      int d;
      int m;
      int f;
      int probe;
      int exp;
   } vec_t;

   vec_t vecs [12];

   initial begin
      vecs[0]  = '{0, 0, 0,     5,     5};
      vecs[1]  = '{0, 0, 0,     255,   255};
      vecs[2]  = '{0, 1, 0,     0,     255};
      vecs[3]  = '{0, 0, 'hF0,  'h10,  'h00};
      vecs[4]  = '{0, 0, 'hF0,  'hFF,  'hEF};
      vecs[5]  = '{0, 2, 'hA5,  'h80,  'hA5};
      vecs[6]  = '{1, 1, 0,     0,     15};
      vecs[7]  = '{1, 1, 0,     15,    0};
      vecs[8]  = '{0, 3, 3,     7,     10};
      vecs[9]  = '{2, 0, 0,     1,     1};
      vecs[10] = '{2, 1, 0,     0,     1};
      vecs[11] = '{2, 2, 'h5A,  1,     'h5A};

      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         en_s[d]   = 1'b0;
         mode_s[d] = 2'd0;
         fill_s[d] = 8'd0;
`ifdef SINIT_VERIFY_EN
         corrupt_s[d] = 1'b0;
`endif
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check("rst_rdy",    int'(rdy_w[d]),  1);
         check("rst_addr",   int'(addr_w[d]), 0);
         check("rst_wrdata", int'(wd_w[d]),   0);
         check("rst_wren",   int'(wren_w[d]), 0);
`ifdef SINIT_VERIFY_EN
         check("rst_err",    int'(err_w[d]),  0);
`endif
      end
      rst_n = 1'b1;
      @(negedge clk);

      // Pattern table: full cycle-checked run, then a probe of the written memory
      for (int v = 0; v < 12; v++) begin
         run(vecs[v].d, vecs[v].m, vecs[v].f, 1'b0, 1'b0);
         check("mem_probe", int'(mem[vecs[v].d][vecs[v].probe]), vecs[v].exp);
      end

      // Randomised runs with mode/fill wiggled mid-run
      for (int n = 0; n < 14; n++) begin
         int d = (n < 2) ? 0 : int'($urandom_range(1, 2));
         run(d, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 1'b1, 1'b0);
      end

      // en held high: back-to-back runs with a single rdy cycle between them
      for (int r = 0; r < 5; r++) run(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 1'b1, 1'b1);
      en_s[1] = 1'b0;
      for (int r = 0; r < 2; r++) run(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 1'b1, 1'b1);
      en_s[0] = 1'b0;
      @(negedge clk);
      check("hold_idle_rdy", int'(rdy_w[0]), 1);

      // Reset at write index 100
      wait_rdy(0);
      mode_s[0] = 2'd0;
      fill_s[0] = 8'd0;
      en_s[0]   = 1'b1;
      @(negedge clk);
      en_s[0] = 1'b0;
      repeat (100) @(negedge clk);
      check("pre_rst_addr", int'(addr_w[0]), 100);
      rst_n = 1'b0;
      #1;
      check("mid_rst_wren", int'(wren_w[0]), 0);
      check("mid_rst_rdy",  int'(rdy_w[0]),  1);
      check("mid_rst_addr", int'(addr_w[0]), 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("in_rst_wren", int'(wren_w[0]), 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_wren", int'(wren_w[0]), 0);
      check("post_rst_rdy",  int'(rdy_w[0]),  1);
      run(0, 1, 0, 1'b0, 1'b0);
      check("post_rst_mem0", int'(mem[0][0]), 255);

`ifdef SINIT_VERIFY_EN
      // Corrupted word 37 must raise err, which then stays until the next start
      corrupt_s[0] = 1'b1;
      run(0, 0, 'h11, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      check("err_sticky", int'(err_w[0]), 1);
      corrupt_s[0] = 1'b0;
      run(0, 2, 'h3C, 1'b0, 1'b0);
      check("err_clean", int'(err_w[0]), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
      $finish;
   end

endmodule
